// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter for N requesters with a registered one-hot grant, its encoded index,
// a valid/ready grant handshake and an optional lock held until the downstream done pulse.
module rr_arbiter_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned LOCK  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic             gnt_ready,
  input  logic             done,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_gnt_valid;
  logic [N-1:0]     r_gnt_onehot;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_busy;

  logic             w_found;
  logic [IDX_W-1:0] w_win_idx;

  // Scan ptr+1, ptr+2, ... modulo N; the first requesting slot wins.
  always_comb begin : p_scan
    int unsigned v_cand;
    logic        v_hit;
    v_cand    = 0;
    v_hit     = 1'b0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      v_cand = 32'(r_ptr) + k;
      if (v_cand >= N) begin
        v_cand = v_cand - N;
      end
      v_hit = |(req & (N'(1) << v_cand));
      if (!w_found && v_hit) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'(v_cand);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_ptr        <= IDX_W'(N - 1);
      r_gnt_valid  <= 1'b0;
      r_gnt_onehot <= '0;
      r_gnt_idx    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_GRANT;
            r_gnt_valid  <= 1'b1;
            r_gnt_onehot <= N'(1) << w_win_idx;
            r_gnt_idx    <= w_win_idx;
            r_busy       <= 1'b1;
          end
        end
        S_GRANT: begin
          // Grant is frozen until the handshake; done is ignored here.
          if (gnt_ready) begin
            if (LOCK != 0) begin
              r_state     <= S_LOCKED;
              r_gnt_valid <= 1'b0;
            end else begin
              r_state      <= S_IDLE;
              r_ptr        <= r_gnt_idx;
              r_gnt_valid  <= 1'b0;
              r_gnt_onehot <= '0;
              r_gnt_idx    <= '0;
              r_busy       <= 1'b0;
            end
          end
        end
        S_LOCKED: begin
          if (done) begin
            r_state      <= S_IDLE;
            r_ptr        <= r_gnt_idx;
            r_gnt_onehot <= '0;
            r_gnt_idx    <= '0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_gnt_valid  <= 1'b0;
          r_gnt_onehot <= '0;
          r_gnt_idx    <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_onehot = r_gnt_onehot;
  assign gnt_idx    = r_gnt_idx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Directed bench for rr_arbiter_enc: a locking N=4 instance and a non-locking N=3 instance,
// expected grant indices queued as stimulus is applied and popped when a grant appears.
module tb_rr_arbiter_enc;

  logic       clk;
  logic       resetn;

  logic [3:0] req4;
  logic       rdy4;
  logic       done4;
  logic       gnt_valid4;
  logic [3:0] gnt_onehot4;
  logic [1:0] gnt_idx4;
  logic       busy4;

  logic [2:0] req3;
  logic       rdy3;
  logic       done3;
  logic       gnt_valid3;
  logic [2:0] gnt_onehot3;
  logic [1:0] gnt_idx3;
  logic       busy3;

  int n_checks;
  int n_fail;
  int q4[$];
  int q3[$];

  rr_arbiter_enc #(.N(4), .IDX_W(2), .LOCK(1)) u_dut4 (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req4),
    .gnt_ready  (rdy4),
    .done       (done4),
    .gnt_valid  (gnt_valid4),
    .gnt_onehot (gnt_onehot4),
    .gnt_idx    (gnt_idx4),
    .busy       (busy4)
  );

  rr_arbiter_enc #(.N(3), .IDX_W(2), .LOCK(0)) u_dut3 (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req3),
    .gnt_ready  (rdy3),
    .done       (done3),
    .gnt_valid  (gnt_valid3),
    .gnt_onehot (gnt_onehot3),
    .gnt_idx    (gnt_idx3),
    .busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant on the N=4 instance and compare it with the queue head.
  task automatic wait_g4(input string tag);
    int n;
    int e;
    n = 0;
    while (gnt_valid4 !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(gnt_valid4), 32'd1);
    e = (q4.size() > 0) ? q4.pop_front() : 99;
    chk({tag, "_idx"}, 32'(gnt_idx4), 32'(e));
    chk({tag, "_onehot"}, 32'(gnt_onehot4), 32'd1 << e);
    chk({tag, "_busy"}, 32'(busy4), 32'd1);
  endtask

  task automatic wait_g3(input string tag);
    int n;
    int e;
    n = 0;
    while (gnt_valid3 !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(gnt_valid3), 32'd1);
    e = (q3.size() > 0) ? q3.pop_front() : 99;
    chk({tag, "_idx"}, 32'(gnt_idx3), 32'(e));
    chk({tag, "_onehot"}, 32'(gnt_onehot3), 32'd1 << e);
    chk({tag, "_busy"}, 32'(busy3), 32'd1);
  endtask

  initial begin
    int order4[5];
    int order3[4];
    order4 = '{0, 1, 2, 3, 0};
    order3 = '{0, 1, 2, 0};
    n_checks = 0;
    n_fail   = 0;
    resetn = 1'b0;
    req4 = '0; rdy4 = 1'b0; done4 = 1'b0;
    req3 = '0; rdy3 = 1'b0; done3 = 1'b0;
    step();
    step();

    chk("rst4_valid",  32'(gnt_valid4),  32'd0);
    chk("rst4_onehot", 32'(gnt_onehot4), 32'd0);
    chk("rst4_idx",    32'(gnt_idx4),    32'd0);
    chk("rst4_busy",   32'(busy4),       32'd0);
    chk("rst3_valid",  32'(gnt_valid3),  32'd0);
    chk("rst3_busy",   32'(busy3),       32'd0);

    // Full rotation with lock, handshake and a done pulse two cycles later.
    resetn = 1'b1;
    req4   = 4'b1111;
    foreach (order4[i]) begin
      q4.push_back(order4[i]);
      wait_g4("rr4");
      rdy4 = 1'b1;
      step();
      chk("rr4_lock_valid", 32'(gnt_valid4), 32'd0);
      chk("rr4_lock_busy",  32'(busy4),      32'd1);
      chk("rr4_lock_hold",  32'(gnt_onehot4), 32'd1 << order4[i]);
      rdy4 = 1'b0;
      step();
      chk("rr4_wait_busy", 32'(busy4), 32'd1);
      done4 = 1'b1;
      step();
      chk("rr4_done_busy",  32'(busy4),       32'd0);
      chk("rr4_done_valid", 32'(gnt_valid4),  32'd0);
      chk("rr4_done_oh",    32'(gnt_onehot4), 32'd0);
      done4 = 1'b0;
    end

    // Grant held stable while ready is low, even when the winner drops its request.
    req4   = '0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    req4   = 4'b1010;
    q4.push_back(1);
    wait_g4("hold");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req4 = 4'b1000;
      chk("hold_idx",    32'(gnt_idx4),    32'd1);
      chk("hold_onehot", 32'(gnt_onehot4), 32'b0010);
      chk("hold_valid",  32'(gnt_valid4),  32'd1);
      step();
    end
    rdy4 = 1'b1;
    step();
    rdy4 = 1'b0;
    chk("hs_valid",  32'(gnt_valid4),  32'd0);
    chk("hs_busy",   32'(busy4),       32'd1);
    chk("hs_onehot", 32'(gnt_onehot4), 32'b0010);
    chk("hs_idx",    32'(gnt_idx4),    32'd1);

    // Locked: new requests wait for done.
    req4 = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("locked_valid", 32'(gnt_valid4), 32'd0);
      chk("locked_busy",  32'(busy4),      32'd1);
    end
    done4 = 1'b1;
    step();
    done4 = 1'b0;
    chk("unlock_busy",  32'(busy4),      32'd0);
    chk("unlock_valid", 32'(gnt_valid4), 32'd0);
    chk("unlock_idx",   32'(gnt_idx4),   32'd0);
    q4.push_back(0);
    step();
    wait_g4("after_lock");

    // Asynchronous reset mid-GRANT, between clock edges.
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid",  32'(gnt_valid4),  32'd0);
    chk("arst_onehot", 32'(gnt_onehot4), 32'd0);
    chk("arst_idx",    32'(gnt_idx4),    32'd0);
    chk("arst_busy",   32'(busy4),       32'd0);
    step();
    resetn = 1'b1;
    req4   = 4'b1000;
    q4.push_back(3);
    step();
    chk("arst_latency", 32'(gnt_valid4), 32'd1);
    wait_g4("arst_grant");

    // Ready and done together in GRANT: lock taken, done ignored.
    rdy4  = 1'b1;
    done4 = 1'b1;
    step();
    rdy4  = 1'b0;
    done4 = 1'b0;
    chk("rdydone_valid", 32'(gnt_valid4), 32'd0);
    chk("rdydone_busy",  32'(busy4),      32'd1);
    step();
    chk("rdydone_still", 32'(busy4), 32'd1);
    done4 = 1'b1;
    step();
    done4 = 1'b0;
    chk("rdydone_rel", 32'(busy4), 32'd0);
    req4 = 4'b1001;
    q4.push_back(0);
    step();
    wait_g4("ptr_wrap");

    // N=3 without lock: wrap 0,1,2,0 with a one-cycle bubble after each handshake.
    req3 = 3'b111;
    rdy3 = 1'b1;
    foreach (order3[i]) begin
      q3.push_back(order3[i]);
      wait_g3("rr3");
      step();
      chk("rr3_bubble_valid", 32'(gnt_valid3), 32'd0);
      chk("rr3_bubble_busy",  32'(busy3),      32'd0);
    end

    // Single requester: repeated grants, done toggling has no effect.
    req3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      q3.push_back(2);
      done3 = ~done3;
      wait_g3("single3");
      done3 = ~done3;
      step();
      chk("single3_gap", 32'(gnt_valid3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
